// File: rtl/ej32_mem_arb.sv
// ej32_mem_arb: shares one byte-wide synchronous memory port between the
// instruction-fetch path and the LS unit.
// Each fetch grant moves one byte. Each LS grant runs an atomic big-endian
// burst of 1, 2 or 4 bytes.
// Optional feature: define EJ32_ARB_RR_EN for alternating fetch/LS priority.
// Without it, LS always has priority over fetch.
module ej32_mem_arb #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [7:0]    if_data,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [1:0]    ls_len,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic [31:0]   ls_rdata,
  output logic          ls_done,
  output logic          ls_bsy,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [7:0]    mem_wd,
  input  logic [7:0]    mem_rd
);

`ifdef EJ32_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, LS_RD, LS_WR, LS_FIN} state_t;
  typedef enum logic [1:0] {T_NONE, T_IF, T_LS} tag_t;

  state_t        state_q, state_d;
  tag_t          tag_q, tag_d;
  logic [1:0]    k_q, k_d;       // next byte index of the burst
  logic [1:0]    n_q, n_d;       // burst length mod 4 (4 bytes -> 0)
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          lg_q, lg_d;     // 1 = last grant went to LS
  logic          ls_win;

  // Length code to byte count mod 4. Once k wraps back to n, every byte has issued.
  function automatic logic [1:0] len_n(input logic [1:0] len);
    return len[1] ? 2'd0 : (len[0] ? 2'd2 : 2'd1);
  endfunction

  // Byte k of a right-aligned n-byte word, MSB first
  function automatic logic [7:0] wbyte(input logic [31:0] w, input logic [1:0] n,
                                       input logic [1:0] k);
    logic [1:0] idx;
    idx = n - 2'd1 - k;
    return w[{idx, 3'b000} +: 8];
  endfunction

  // Return data is routed by the issue-time tag, whichever side holds the grant now
  assign if_ack   = (tag_q == T_IF);
  assign if_data  = mem_rd;
  assign ls_rdata = rdata_q;
  assign ls_bsy   = (state_q == LS_RD) || (state_q == LS_WR) || (state_q == LS_FIN);
  assign ls_win   = ls_req & ~(RR_EN & if_req & lg_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tag_q   <= T_NONE;
      k_q     <= '0;
      n_q     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      lg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      k_q     <= k_d;
      n_q     <= n_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      lg_q    <= lg_d;
    end
  end

  // Grant decision, burst sequencing and memory-port drive
  always_comb begin
    state_d = state_q;
    tag_d   = T_NONE;
    k_d     = k_q;
    n_d     = n_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    acc_d   = (tag_q == T_LS) ? {acc_q[23:0], mem_rd} : acc_q;
    rdata_d = rdata_q;
    lg_d    = lg_q;
    mem_a   = '0;
    mem_we  = 1'b0;
    mem_wd  = '0;
    ls_done = 1'b0;
    case (state_q)
      IDLE, FETCH: begin
        // rst gates the grant so the port stays quiet while reset is held
        if (rst && ls_win) begin
          we_d    = ls_we;
          n_d     = len_n(ls_len);
          addr_d  = ls_addr;
          wdata_d = ls_wdata;
          k_d     = 2'd1;
          acc_d   = '0;
          lg_d    = 1'b1;
          mem_a   = ls_addr;
          mem_we  = ls_we;
          mem_wd  = ls_we ? wbyte(ls_wdata, len_n(ls_len), 2'd0) : 8'h00;
          tag_d   = ls_we ? T_NONE : T_LS;
          state_d = ls_we ? LS_WR : LS_RD;
        end else if (rst && if_req) begin
          mem_a   = if_addr;
          tag_d   = T_IF;
          lg_d    = 1'b0;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      LS_RD: begin
        if (k_q != n_q) begin
          mem_a = addr_q + AW'(k_q);
          tag_d = T_LS;
          k_d   = k_q + 2'd1;
        end else begin
          // last byte is on mem_rd now
          rdata_d = {acc_q[23:0], mem_rd};
          state_d = LS_FIN;
        end
      end
      LS_WR: begin
        if (k_q != n_q) begin
          mem_a  = addr_q + AW'(k_q);
          mem_we = 1'b1;
          mem_wd = wbyte(wdata_q, n_q, k_q);
          k_d    = k_q + 2'd1;
        end else begin
          ls_done = 1'b1;
          state_d = IDLE;
        end
      end
      LS_FIN: begin
        ls_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Bench for ej32_mem_arb: reset, table vectors, contention/reset corners,
// then random traffic against a cycle-offset transaction model.
module tb_ej32_mem_arb;

`ifdef EJ32_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [16:0] if_addr = '0, ls_addr = '0;
  logic [1:0]  ls_len = '0;
  logic [31:0] ls_wdata = '0;
  logic        if_ack, ls_done, ls_bsy, mem_we;
  logic [7:0]  if_data, mem_wd, mem_rd;
  logic [31:0] ls_rdata;
  logic [16:0] mem_a;

  logic [7:0] mem [0:131071];

  int n_cmp = 0;
  int n_bad = 0;

  ej32_mem_arb #(.AW(17)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_bsy(ls_bsy),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // synchronous byte memory, read data one cycle after its address
  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
    mem_rd <= mem[mem_a];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [16:0] ifa, input logic lsr,
                       input logic we, input logic [1:0] len, input logic [16:0] la,
                       input logic [31:0] wd);
    if_req = ifr; if_addr = ifa; ls_req = lsr; ls_we = we; ls_len = len;
    ls_addr = la; ls_wdata = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 17'h55, 1'b1, 1'b1, 2'd3, 17'h77, 32'hFFFF_FFFF);
    #1;
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_wd", 32'(mem_wd), 32'h0);
    chk("rst_if_ack", 32'(if_ack), 32'h0);
    chk("rst_ls_done", 32'(ls_done), 32'h0);
    chk("rst_ls_bsy", 32'(ls_bsy), 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, '0);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ifr; logic [16:0] ifa;
    logic        lsr; logic we; logic [1:0] len; logic [16:0] la; logic [31:0] wd;
    logic [16:0] ea; logic ewe; logic [7:0] ewd;
    logic        eack; logic [7:0] edat;
    logic        edone; logic ebsy; logic [31:0] erd;
  } vec_t;
  vec_t tbl [17];

  // transaction-level model state for the random phase
  int          c, a_c, done_c, m_n;
  bit          act, m_we, last_ls, fpend;
  logic [16:0] m_base;
  logic [31:0] m_wd, pend_rd, exp_rd;
  logic [7:0]  fdata;

  task automatic model_init();
    c = 0; act = 0; last_ls = 0; fpend = 0; fdata = '0; exp_rd = '0;
  endtask

  task automatic rnd_step();
    logic        e_we, e_done, e_bsy, nf, lswin;
    logic [16:0] e_a;
    logic [7:0]  e_wd, nfd;
    int          off;
    @(negedge clk);
    drive($urandom_range(0, 1) == 1, 17'($urandom), $urandom_range(0, 3) == 0,
          1'($urandom), 2'($urandom), 17'($urandom), $urandom);
    #1;
    e_we = 0; e_a = '0; e_wd = '0; e_done = 0; e_bsy = 0; nf = 0; nfd = '0;
    if (!act) begin
      lswin = ls_req && !(RR && if_req && last_ls);
      if (lswin) begin
        act = 1; a_c = c; m_we = ls_we; m_base = ls_addr; m_wd = ls_wdata;
        m_n = (ls_len >= 2) ? 4 : int'(ls_len) + 1;
        done_c = c + m_n + (m_we ? 0 : 1);
        last_ls = 1;
        pend_rd = '0;
        for (int k = 0; k < m_n; k++) pend_rd = (pend_rd << 8) | 32'(mem[m_base + 17'(k)]);
      end else if (if_req) begin
        e_a = if_addr; nf = 1; nfd = mem[if_addr]; last_ls = 0;
      end
    end
    if (act) begin
      off = c - a_c;
      e_bsy = (off >= 1);
      if (off < m_n) begin
        e_a = m_base + 17'(off);
        if (m_we) begin
          e_we = 1;
          e_wd = 8'(m_wd >> (8 * (m_n - 1 - off)));
        end
      end
      if (c == done_c) begin
        e_done = 1;
        if (!m_we) exp_rd = pend_rd;
        act = 0;
      end
    end
    chk("r_mem_a", 32'(mem_a), 32'(e_a));
    chk("r_mem_we", 32'(mem_we), 32'(e_we));
    if (e_we) chk("r_mem_wd", 32'(mem_wd), 32'(e_wd));
    chk("r_if_ack", 32'(if_ack), 32'(fpend));
    if (fpend) chk("r_if_data", 32'(if_data), 32'(fdata));
    chk("r_ls_done", 32'(ls_done), 32'(e_done));
    chk("r_ls_bsy", 32'(ls_bsy), 32'(e_bsy));
    chk("r_ls_rdata", ls_rdata, exp_rd);
    fpend = nf; fdata = nfd;
    c++;
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] <= 8'($urandom);
    mem[17'h100] <= 8'h10; mem[17'h101] <= 8'h20; mem[17'h102] <= 8'h30; mem[17'h103] <= 8'h40;
    mem[17'h200] <= 8'hDE; mem[17'h201] <= 8'hAD; mem[17'h202] <= 8'hBE; mem[17'h203] <= 8'hEF;

    //          ifr  ifa      lsr  we   len   la        wd            ea        ewe  ewd    ack  dat    done bsy  rdata
    tbl[0]  = '{1'b1, 17'h100, 1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h100,   1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 17'h101, 1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h101,   1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 17'h102, 1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h102,   1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 17'h103, 1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h103,   1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h0,     1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h0,     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 17'h0,   1'b1, 1'b1, 2'd1, 17'h1FFFF, 32'h1234,   17'h1FFFF, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h0,     1'b1, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h0,     1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h0,     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 17'h0,   1'b1, 1'b0, 2'd3, 17'h200,   32'h0,      17'h200,   1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h201,   1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h202,   1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h203,   1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0};
    tbl[14] = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h0,     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0};
    tbl[15] = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h0,     1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 32'hDEADBEEF};
    tbl[16] = '{1'b0, 17'h0,   1'b0, 1'b0, 2'd0, 17'h0,     32'h0,      17'h0,     1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF};

    do_reset();

    // fetch stream, short wrapping write, word read
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i].ifr, tbl[i].ifa, tbl[i].lsr, tbl[i].we, tbl[i].len, tbl[i].la, tbl[i].wd);
      #1;
      chk($sformatf("t%0d_mem_a", i), 32'(mem_a), 32'(tbl[i].ea));
      chk($sformatf("t%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].ewe));
      if (tbl[i].ewe) chk($sformatf("t%0d_mem_wd", i), 32'(mem_wd), 32'(tbl[i].ewd));
      chk($sformatf("t%0d_if_ack", i), 32'(if_ack), 32'(tbl[i].eack));
      if (tbl[i].eack) chk($sformatf("t%0d_if_data", i), 32'(if_data), 32'(tbl[i].edat));
      chk($sformatf("t%0d_ls_done", i), 32'(ls_done), 32'(tbl[i].edone));
      chk($sformatf("t%0d_ls_bsy", i), 32'(ls_bsy), 32'(tbl[i].ebsy));
      chk($sformatf("t%0d_ls_rdata", i), ls_rdata, tbl[i].erd);
    end
    chk("wrap_wr_hi", 32'(mem[17'h1FFFF]), 32'h12);
    chk("wrap_wr_lo", 32'(mem[17'h00000]), 32'h34);

    // contention: fetch in N, byte read requested in N+1 and held high
    @(negedge clk); drive(1'b1, 17'h100, 1'b0, 1'b0, 2'd0, 17'h0, 32'h0); #1;
    chk("cn_N_mem_a", 32'(mem_a), 32'h100);
    @(negedge clk); drive(1'b1, 17'h101, 1'b1, 1'b0, 2'd0, 17'h200, 32'h0); #1;
    chk("cn_N1_if_ack", 32'(if_ack), 32'h1);
    chk("cn_N1_if_data", 32'(if_data), 32'h10);
    chk("cn_N1_mem_a", 32'(mem_a), 32'h200);
    @(negedge clk); #1;
    chk("cn_N2_mem_a", 32'(mem_a), 32'h0);
    chk("cn_N2_bsy", 32'(ls_bsy), 32'h1);
    chk("cn_N2_if_ack", 32'(if_ack), 32'h0);
    @(negedge clk); #1;
    chk("cn_N3_mem_a", 32'(mem_a), 32'h0);
    chk("cn_N3_done", 32'(ls_done), 32'h1);
    chk("cn_N3_rdata", ls_rdata, 32'h0000_00DE);
    @(negedge clk); #1;
    chk("cn_N4_mem_a", 32'(mem_a), RR ? 32'h101 : 32'h200);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, '0); #1;
    chk("cn_N5_if_ack", 32'(if_ack), RR ? 32'h1 : 32'h0);
    if (RR) chk("cn_N5_if_data", 32'(if_data), 32'h20);

    // reset in the middle of a 4-byte write
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) mem[17'h300 + 17'(i)] <= 8'h00;
    @(negedge clk); drive(1'b0, '0, 1'b1, 1'b1, 2'd2, 17'h300, 32'hA1B2C3D4); #1;
    chk("rm_A_mem_we", 32'(mem_we), 32'h1);
    chk("rm_A_mem_wd", 32'(mem_wd), 32'hA1);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, '0); rst = 1'b0; #1;
    chk("rm_A1_mem_we", 32'(mem_we), 32'h0);
    chk("rm_A1_bsy", 32'(ls_bsy), 32'h0);
    chk("rm_A1_done", 32'(ls_done), 32'h0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rm_A2_done", 32'(ls_done), 32'h0);
    @(negedge clk); #1;
    chk("rm_A3_done", 32'(ls_done), 32'h0);
    chk("rm_A3_bsy", 32'(ls_bsy), 32'h0);
    chk("rm_byte0", 32'(mem[17'h300]), 32'hA1);
    chk("rm_byte1", 32'(mem[17'h301]), 32'h00);

    // random traffic against the model
    do_reset();
    model_init();
    for (int i = 0; i < 3000; i++) rnd_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
